// File: rtl/timer_counter.sv
// Memory-mapped down-counter with IRQ; one-shot (held IRQ) or auto-reload (1-cycle pulse).
// Latency: rdata/irq combinational; first IRQ at E(PRESET+2) after the EN write edge. No backpressure.
// Optional TC_PRESCALE_EN: COUNT steps once every PRESCALE clocks in CNT.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        en_next;
    logic        mode_reload;
    logic        tick;
    logic        unused_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel         = addr[3:2];
    assign wr_ctrl     = we && hit && (sel == 2'd0);
    assign wr_preset   = we && hit && (sel == 2'd1);
    assign mode_reload = (ctrl_q[2:1] == 2'b01);
    assign unused_bits = ^{addr[1:0], wdata[31:4]};

    // IDLE must see an EN written on this very edge so LOAD starts at E0.
    assign en_next = wr_ctrl ? wdata[0] : ctrl_q[0];

`ifdef TC_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PSC_W-1:0] psc_q, psc_d;

    // First CNT cycle is a tick, so the first IRQ lands at E(PRESET*PRESCALE+2).
    assign tick = (psc_q == '0);

    always_comb begin
        psc_d = psc_q;
        if (state_q != ST_CNT) begin
            psc_d = '0;
        end else if (psc_q == PSC_W'(PRESCALE - 1)) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en_next) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (tick) begin
                    if (count_q != 32'd0) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        irq_flag_d = 1'b1;
                        state_d    = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (mode_reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus writes override the FSM's update of the same register.
        if (wr_preset) begin
            preset_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d     = wdata[3:0];
            irq_flag_d = 1'b0;
            if (!wdata[0]) begin
                state_d = ST_IDLE;
                count_d = count_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (sel)
                2'd0:    rdata = {28'd0, ctrl_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_flag_q & ctrl_q[3];

endmodule
